// File: rtl/a25_wb_pkg.sv
// a25_wb_pkg: shared types and constants for the Amber25 three-port Wishbone arbiter
package a25_wb_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ} a25_wb_state_e;
  localparam int A25_WB_PORTS = 3;
  localparam logic [1:0] UNCACHED = 2'd0;
  localparam logic [1:0] DCACHE = 2'd1;
  localparam logic [1:0] ICACHE = 2'd2;
  localparam logic [127:0] A25_WB_ERR_DATA = 128'hDEADDEAD_DEADDEAD_DEADDEAD_DEADDEAD;
endpackage

// File: rtl/a25_wb_watchdog.sv
// a25_wb_watchdog: 8-bit strobe-cycle counter that flags expiry at TIMEOUT_CYCLES
module a25_wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] r_count;
  always_ff @(posedge i_clk)
    if (i_rst || i_clr) r_count <= '0;
    else if (i_en) r_count <= r_count + 8'd1;
  assign o_expired = i_en && r_count == LIMIT;
endmodule

// File: rtl/a25_wishbone_arb.sv
// a25_wishbone_arb: fixed-priority 3-port Wishbone B3 master arbiter; watchdog built under A25_WB_WATCHDOG_EN
module a25_wishbone_arb
  import a25_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [A25_WB_PORTS-1:0]     i_port_valid,
  input  logic [A25_WB_PORTS-1:0]     i_port_write,
  input  logic [A25_WB_PORTS*128-1:0] i_port_wdata,
  input  logic [A25_WB_PORTS*16-1:0]  i_port_be,
  input  logic [A25_WB_PORTS*32-1:0]  i_port_addr,
  output logic [A25_WB_PORTS-1:0]     o_port_accepted,
  output logic [127:0]              o_port_rdata,
  output logic [A25_WB_PORTS-1:0]     o_port_rdata_valid,
  output logic [31:0]               o_wb_adr,
  output logic [15:0]               o_wb_sel,
  output logic                      o_wb_we,
  output logic [127:0]              o_wb_dat,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  input  logic [127:0]              i_wb_dat,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_err,
  output logic                      o_bus_err
);
  a25_wb_state_e r_state, w_next;
  logic [1:0] r_owner, w_idx;
  logic [A25_WB_PORTS-1:0] w_grant, r_rdata_valid;
  logic w_busy, w_ack, w_err, w_to, w_term, w_expired, r_we, r_bus_err;
  logic [31:0] r_adr;
  logic [15:0] r_sel;
  logic [127:0] r_dat, r_rdata;
`ifdef A25_WB_WATCHDOG_EN
  a25_wb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(|w_grant),
    .i_en(w_busy),
    .o_expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif
  always_comb begin
    w_idx = i_port_valid[0] ? 2'd0 : i_port_valid[1] ? 2'd1 : 2'd2;
    w_grant = (r_state == IDLE && !i_rst && |i_port_valid) ? 3'b001 << w_idx : '0;
    w_busy = r_state != IDLE;
    w_ack = w_busy && i_wb_ack;
    w_err = w_busy && !i_wb_ack && i_wb_err;
    w_to = w_busy && !i_wb_ack && !i_wb_err && w_expired;
    w_term = w_ack || w_err || w_to;
    w_next = |w_grant ? (i_port_write[w_idx] ? WRITE : READ) : w_term ? IDLE : r_state;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_adr <= '0;
      r_sel <= '0;
      r_we <= 1'b0;
      r_dat <= '0;
      r_rdata <= '0;
      r_rdata_valid <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_bus_err <= w_err || w_to;
      r_rdata_valid <= (w_term && r_state == READ) ? 3'b001 << r_owner : '0;
      if (w_term && r_state == READ) r_rdata <= w_ack ? i_wb_dat : A25_WB_ERR_DATA;
      if (|w_grant) begin
        r_owner <= w_idx;
        r_adr <= i_port_addr[w_idx*32 +: 32];
        r_we <= i_port_write[w_idx];
        r_sel <= i_port_write[w_idx] ? i_port_be[w_idx*16 +: 16] : 16'hFFFF;
        r_dat <= i_port_wdata[w_idx*128 +: 128];
      end
    end
  assign o_port_accepted = w_grant;
  assign o_port_rdata = r_rdata;
  assign o_port_rdata_valid = r_rdata_valid;
  assign o_wb_adr = r_adr;
  assign o_wb_sel = r_sel;
  assign o_wb_we = r_we;
  assign o_wb_dat = r_dat;
  assign o_wb_cyc = w_busy;
  assign o_wb_stb = w_busy;
  assign o_bus_err = r_bus_err;
endmodule
